// File: rtl/magic_pkg.sv
// Shared types and sizing for the MAGIC NOR sequencer.
// Optional build macro: MAGIC_INIT_CYCLE_EN (adds the output-cell init cycle).
package magic_pkg;

    localparam int unsigned N_IN        = 5;
    localparam int unsigned N_CELLS     = 32;
    localparam int unsigned N_OPS       = 32;
    localparam int unsigned AW          = $clog2(N_CELLS);
    localparam int unsigned PCW         = $clog2(N_OPS);
    localparam int unsigned OP_W        = 1 + 3 * AW;
    localparam int unsigned CONST0_CELL = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT,
        ST_EVAL,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic          last;
        logic [AW-1:0] dst;
        logic [AW-1:0] src_a;
        logic [AW-1:0] src_b;
    } op_t;

    // Cells 0..N_IN hold the constant and the primary inputs; gates may not overwrite them.
    function automatic logic [AW-1:0] first_writable_cell();
        return AW'(N_IN + 1);
    endfunction

endpackage

// File: rtl/magic_nor_sequencer_if.sv
// Program-load and start/done handshake bundle for the MAGIC NOR sequencer.
interface magic_nor_sequencer_if;
    import magic_pkg::*;

    logic            prog_we;
    logic [PCW-1:0]  prog_addr;
    logic [OP_W-1:0] prog_data;
    logic            start;
    logic [N_IN-1:0] in_vec;
    logic [AW-1:0]   out_sel;
    logic            busy;
    logic            done;
    logic            result;
    logic            err;

    modport master (
        output prog_we, prog_addr, prog_data, start, in_vec, out_sel,
        input  busy, done, result, err
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, in_vec, out_sel,
        output busy, done, result, err
    );

endinterface

// File: rtl/magic_prog_mem.sv
// Gate program store: synchronous write, combinational read at the program counter.
module magic_prog_mem
    import magic_pkg::*;
(
    input  logic           clk,
    input  logic           we,
    input  logic [PCW-1:0] waddr,
    input  op_t            wdata,
    input  logic [PCW-1:0] raddr,
    output op_t            rdata_c
);

    // Deliberately not reset: contents are undefined until the loader writes them.
    op_t mem_q [N_OPS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/magic_nor_sequencer.sv
// Executes a stored NOR netlist one gate at a time over one modelled MAGIC crossbar row.
// Build macro MAGIC_INIT_CYCLE_EN inserts a per-gate output-cell initialisation cycle.
module magic_nor_sequencer
    import magic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    magic_nor_sequencer_if.slave  bus
);

    state_e             state_q,   state_d;
    logic [PCW-1:0]     pc_q,      pc_d;
    logic [N_CELLS-1:0] cells_q,   cells_d;
    logic [N_IN-1:0]    in_vec_q,  in_vec_d;
    logic [AW-1:0]      out_sel_q, out_sel_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               result_q,  result_d;
    logic               err_q,     err_d;

    op_t  cur_op_c;
    logic prog_wr_c;
    logic dst_legal_c;
    logic nor_c;
    logic last_op_c;

    // Loader writes are honoured only while idle.
    assign prog_wr_c = bus.prog_we && (state_q == ST_IDLE);

    magic_prog_mem u_prog_mem (
        .clk     (clk),
        .we      (prog_wr_c),
        .waddr   (bus.prog_addr),
        .wdata   (op_t'(bus.prog_data)),
        .raddr   (pc_q),
        .rdata_c (cur_op_c)
    );

    assign dst_legal_c = (cur_op_c.dst >= first_writable_cell());
    assign nor_c       = ~(cells_q[cur_op_c.src_a] | cells_q[cur_op_c.src_b]);
    assign last_op_c   = cur_op_c.last || (pc_q == PCW'(N_OPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            cells_q   <= '0;
            in_vec_q  <= '0;
            out_sel_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cells_q   <= cells_d;
            in_vec_q  <= in_vec_d;
            out_sel_q <= out_sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cells_d   = cells_q;
        in_vec_d  = in_vec_q;
        out_sel_d = out_sel_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_LOAD;
                    busy_d    = 1'b1;
                    in_vec_d  = bus.in_vec;
                    out_sel_d = bus.out_sel;
                end
            end

            ST_LOAD: begin
                cells_d         = '0;
                cells_d[N_IN:1] = in_vec_q;
                pc_d            = '0;
                err_d           = 1'b0;
`ifdef MAGIC_INIT_CYCLE_EN
                state_d = ST_INIT;
`else
                state_d = ST_EVAL;
`endif
            end

            ST_INIT: begin
`ifdef MAGIC_INIT_CYCLE_EN
                if (dst_legal_c) begin
                    cells_d[cur_op_c.dst] = 1'b1;
                end
`endif
                state_d = ST_EVAL;
            end

            ST_EVAL: begin
                // The init build ANDs into the pre-set output cell, so dst == src reads back the 1.
                if (dst_legal_c) begin
`ifdef MAGIC_INIT_CYCLE_EN
                    cells_d[cur_op_c.dst] = cells_q[cur_op_c.dst] & nor_c;
`else
                    cells_d[cur_op_c.dst] = nor_c;
`endif
                end else begin
                    err_d = 1'b1;
                end
                if (last_op_c) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d = pc_q + PCW'(1);
`ifdef MAGIC_INIT_CYCLE_EN
                    state_d = ST_INIT;
`else
                    state_d = ST_EVAL;
`endif
                end
            end

            ST_DONE: begin
                result_d = cells_q[out_sel_q];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        cells_d[AW'(CONST0_CELL)] = 1'b0;
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule

// File: doc/magic_nor_sequencer.md
# magic_nor_sequencer

Executes a stored NOR-only netlist one gate at a time over a small bit-cell array that models one MAGIC crossbar row. The mapping flow emits NOR netlists; this block is the consuming end. It loads a gate program, applies an input vector, evaluates gates in program order, and returns a selected cell as the result. It sits between the netlist loader (program write port) and the benchmark harness (start/done handshake).

## Interface
- N_IN, 5, number of primary inputs; mapped to cells 1..N_IN
- N_CELLS, 32, bit cells; cell 0 is hardwired constant 0
- N_OPS, 32, program memory depth
- AW, $clog2(N_CELLS), cell address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- prog_we  in  1  program write strobe; honoured only in IDLE
- prog_addr  in  $clog2(N_OPS)  program slot
- prog_data  in  1+3*AW  {last, dst, srcA, srcB}
- start  in  1  begin evaluation; honoured only in IDLE
- in_vec  in  N_IN  primary inputs; in_vec[i] loads cell i+1; sampled with start
- out_sel  in  AW  result cell; sampled with start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when result is valid
- result  out  1  cell[out_sel], held until the next start
- err  out  1  sticky illegal-write flag; cleared by start

## Operation
- Gate semantics: cell[dst] = ~(cell[srcA] | cell[srcB]). NOT is encoded as srcB = 0.
- States: IDLE, LOAD, INIT, EVAL, DONE.
- IDLE → LOAD on start. LOAD clears cells N_IN+1..N_CELLS-1, writes in_vec into cells 1..N_IN, sets pc = 0, and clears err.
- LOAD → INIT. INIT → EVAL. EVAL → INIT for the next op, or → DONE when last = 1 or pc = N_OPS-1.
- DONE registers result, pulses done for one cycle, then returns to IDLE.
- Illegal dst (0..N_IN):
  - the write is suppressed and err is set;
  - sequencing continues.
- Sources may be any cell, including uninitialised ones, which read 0 after LOAD.
- start or prog_we while busy: ignored, no side effects.
- prog_we and start in the same IDLE cycle: the write completes and evaluation starts. The new word is used if that slot is reached.
- Program memory is not cleared by rst; its contents are undefined until written.

## Timing
- Reset values:
  - state = IDLE, busy = 0, done = 0, result = 0, err = 0;
  - all cells = 0;
  - pc = 0.
- Per-gate cost G: 2 cycles with the init cycle compiled in, 1 cycle without it.
- With start sampled at edge t and K ops executed, done is high in cycle t+2+K·G.
- result becomes valid in the same cycle as done.
- rst mid-run aborts immediately: IDLE, no done pulse, cells cleared.
- Program write latency: 1 cycle. The write is visible to a start issued in the following cycle.

## Configuration
- MAGIC_INIT_CYCLE_EN defined:
  - INIT drives cell[dst] = 1;
  - EVAL applies cell[dst] = cell[dst] & ~(srcA | srcB), which models the MAGIC output-memristor initialisation;
  - G = 2.
- MAGIC_INIT_CYCLE_EN undefined:
  - INIT is skipped and EVAL writes the NOR directly;
  - G = 1.
- The final cell values are identical in both configurations whenever dst differs from srcA and srcB.
- With the init cycle compiled in, dst == src yields 0 (the initialised 1 is read back).

## Structure
- Package magic_pkg:
  - state enum;
  - op_t struct {last, dst, srcA, srcB};
  - CONST0_CELL = 0;
  - helper for the first writable cell index.
- One sub-module, magic_prog_mem: N_OPS × op_t, synchronous write, combinational read addressed by pc.
- The cell array, FSM and pc stay in the top module.

## Test plan
- Reset: assert rst mid-EVAL → busy=0, done=0, err=0 and all cells 0 the same cycle; no done pulse follows.
- XOR program, in_vec=5'b00011 (x0=1, x1=1), out_sel=10:
  - ops 6=NOR(1,2), 7=NOR(1,6), 8=NOR(2,6), 9=NOR(7,8), 10=NOR(9,0, last).
  - Expect result=0 at done, with done at t+12 (init cycle compiled in) or t+7 (not compiled in).
- Same XOR program swept over all four (x0,x1) values → result 0,1,1,0.
- Illegal dst: op 0 = NOR(0,0)→dst 3, last → err=1, cell 3 keeps in_vec[2]; the next start clears err.
- No last bit: all N_OPS slots written as NOR(0,0)→6 → done at t+2+N_OPS·G, result(out_sel=6)=1.
- start and prog_we while busy → ignored; the run completes with the original program and the following run uses the unchanged memory.
